// File: rtl/led_strip_streamer.sv
// rtl/led_strip_streamer.sv - WS2812-class LED frame streamer (pixel memory to one-wire NRZ)
//
// Fetches NUM_PIXELS words of CHANNELS x CH_W bits from a 1-cycle-latency pixel
// memory and serialises them MSB first as NRZ pulses, back to back, followed by
// a RESET_CYC low latch gap.
//
// Optional feature macro: LED_BRIGHTNESS_EN (adds the brightness port and
// per-channel scaling of every loaded pixel word).
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous reset, active low
//   frame_start  1-cycle request to send one frame (ignored while busy)
//   continuous   restart automatically after each latch gap
//   pix_addr     pixel read address
//   pix_data     pixel word, valid 1 clk after pix_addr, channel 0 in MSBs
//   busy         high from accepted start until the latch gap ends
//   frame_done   1-cycle pulse on the last latch-gap cycle
//   dout         serial LED data
//   dout_n       inverted serial data for the level-shifter pin
//   brightness   global scale, sampled at frame start (LED_BRIGHTNESS_EN only)

module led_strip_streamer #(
    parameter int NUM_PIXELS = 64,
    parameter int CHANNELS   = 3,
    parameter int CH_W       = 8,
    parameter int ADDR_W     = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1,
    parameter int BIT_CYC    = 15,
    parameter int T0H_CYC    = 4,
    parameter int T1H_CYC    = 10,
    parameter int RESET_CYC  = 3600
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic                     continuous,
    output logic [ADDR_W-1:0]        pix_addr,
    input  logic [CHANNELS*CH_W-1:0] pix_data,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     dout,
    output logic                     dout_n
`ifdef LED_BRIGHTNESS_EN
    ,
    input  logic [7:0]               brightness
`endif
);

    localparam int PIX_BITS  = CHANNELS * CH_W;
    localparam int BIT_CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int IDX_W     = (PIX_BITS > 1) ? $clog2(PIX_BITS) : 1;
    localparam int LAT_W     = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;

    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(BIT_CYC - 1);
    localparam logic [BIT_CNT_W-1:0] T0H_C    = BIT_CNT_W'(T0H_CYC);
    localparam logic [BIT_CNT_W-1:0] T1H_C    = BIT_CNT_W'(T1H_CYC);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(PIX_BITS - 1);
    localparam logic [ADDR_W-1:0]    PIX_LAST = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [LAT_W-1:0]     LAT_LAST = LAT_W'(RESET_CYC - 1);

    if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC &&
          NUM_PIXELS >= 1 && RESET_CYC >= 1)) begin : g_param_check
        $error("led_strip_streamer: illegal bit timing or pixel count parameters");
    end

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PRIME,
        SEND,
        LATCH
    } state_t;

    state_t                 state_q,    state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [IDX_W-1:0]       bit_idx_q,  bit_idx_d;
    logic [LAT_W-1:0]       lat_cnt_q,  lat_cnt_d;
    logic [ADDR_W-1:0]      pix_idx_q,  pix_idx_d;   // pixel currently on the wire
    logic [ADDR_W-1:0]      pix_addr_q, pix_addr_d;  // runs one pixel ahead during the last bit
    logic [PIX_BITS-1:0]    shift_q,    shift_d;
    logic [PIX_BITS-1:0]    hold_q,     hold_d;      // prefetched word waiting for the boundary
    logic [PIX_BITS-1:0]    load_src;
    logic [PIX_BITS-1:0]    load_word;

`ifdef LED_BRIGHTNESS_EN
    logic [7:0]             bright_q,   bright_d;

    // (v * (b + 1)) >> 8 per channel; b = 255 is an exact pass-through.
    function automatic logic [PIX_BITS-1:0] scale_word(input logic [PIX_BITS-1:0] w,
                                                       input logic [7:0]          b);
        logic [PIX_BITS-1:0] r;
        logic [CH_W+8:0]     p;
        r = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            p = {9'd0, w[c*CH_W +: CH_W]} * ({{(CH_W+1){1'b0}}, b} + (CH_W+9)'(1));
            r[c*CH_W +: CH_W] = CH_W'(p >> 8);
        end
        return r;
    endfunction
`endif

    // One loader serves both the first pixel (straight from memory in PRIME)
    // and every later pixel (from the prefetch holding register).
    always_comb begin
        load_src = (state_q == PRIME) ? pix_data : hold_q;
`ifdef LED_BRIGHTNESS_EN
        load_word = scale_word(load_src, bright_q);
`else
        load_word = load_src;
`endif
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        lat_cnt_d  = lat_cnt_q;
        pix_idx_d  = pix_idx_q;
        pix_addr_d = pix_addr_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        frame_done = 1'b0;
`ifdef LED_BRIGHTNESS_EN
        bright_d   = bright_q;
`endif

        case (state_q)
            IDLE: begin
                pix_addr_d = '0;
                pix_idx_d  = '0;
                if (frame_start) begin
                    state_d = FETCH;
`ifdef LED_BRIGHTNESS_EN
                    bright_d = brightness;
`endif
                end
            end

            FETCH: state_d = PRIME;

            PRIME: begin
                shift_d   = load_word;
                bit_cnt_d = '0;
                bit_idx_d = '0;
                state_d   = SEND;
            end

            SEND: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == IDX_LAST) begin
                        bit_idx_d = '0;
                        if (pix_idx_q == PIX_LAST) begin
                            lat_cnt_d = '0;
                            state_d   = LATCH;
                        end else begin
                            pix_idx_d = pix_idx_q + ADDR_W'(1);
                            shift_d   = load_word;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        shift_d   = shift_q << 1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
                // Memory answers the advanced address one cycle later; latch it
                // on the second cycle of the last bit so the boundary is gapless.
                if (bit_idx_q == IDX_LAST && bit_cnt_q == BIT_CNT_W'(1) &&
                    pix_idx_q != PIX_LAST) begin
                    hold_d = pix_data;
                end
            end

            LATCH: begin
                if (lat_cnt_q == LAT_LAST) begin
                    frame_done = 1'b1;
                    pix_addr_d = '0;
                    pix_idx_d  = '0;
                    if (continuous) begin
                        state_d = FETCH;
`ifdef LED_BRIGHTNESS_EN
                        bright_d = brightness;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase

        // Present the next pixel's address on the first cycle of the current
        // pixel's last bit; also covers one-bit pixels entered from PRIME.
        if (state_d == SEND && bit_cnt_d == '0 && bit_idx_d == IDX_LAST &&
            pix_idx_d != PIX_LAST) begin
            pix_addr_d = pix_idx_d + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            lat_cnt_q  <= '0;
            pix_idx_q  <= '0;
            pix_addr_q <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
`ifdef LED_BRIGHTNESS_EN
            bright_q   <= 8'hFF;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            lat_cnt_q  <= lat_cnt_d;
            pix_idx_q  <= pix_idx_d;
            pix_addr_q <= pix_addr_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
`ifdef LED_BRIGHTNESS_EN
            bright_q   <= bright_d;
`endif
        end
    end

    // The pulse is decoded straight from registered state, so it is zero
    // everywhere outside SEND, including the whole latch gap.
    always_comb begin
        busy     = (state_q != IDLE);
        pix_addr = pix_addr_q;
        dout     = (state_q == SEND) &&
                   (bit_cnt_q < (shift_q[PIX_BITS-1] ? T1H_C : T0H_C));
        dout_n   = ~dout;
    end

endmodule

// File: tb/tb_led_strip_streamer.sv
// tb/tb_led_strip_streamer.sv - scoreboard bench for led_strip_streamer (4-pixel and 1-pixel instances)

module tb_led_strip_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, cont_a = 1'b0, start_b = 1'b0, cont_b = 1'b0;
    logic [1:0]  addr_a;
    logic [0:0]  addr_b;
    logic [23:0] data_a = '0, data_b = '0;
    logic        busy_a, done_a, dout_a, doutn_a;
    logic        busy_b, done_b, dout_b, doutn_b;
`ifdef LED_BRIGHTNESS_EN
    logic [7:0]  bright_a = 8'd255, bright_b = 8'd255;
`endif

    logic [23:0] mem_a [4] = '{24'hFF0000, 24'h000000, 24'hAAAAAA, 24'h000001};
    logic [23:0] mem_b = 24'h800001;

    always @(posedge clk) data_a <= mem_a[addr_a];
    always @(posedge clk) data_b <= mem_b;

    led_strip_streamer #(.NUM_PIXELS(4)) u_a (
        .clk(clk), .rst_n(rst_n), .frame_start(start_a), .continuous(cont_a),
        .pix_addr(addr_a), .pix_data(data_a), .busy(busy_a), .frame_done(done_a),
        .dout(dout_a), .dout_n(doutn_a)
`ifdef LED_BRIGHTNESS_EN
        , .brightness(bright_a)
`endif
    );

    led_strip_streamer #(.NUM_PIXELS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .frame_start(start_b), .continuous(cont_b),
        .pix_addr(addr_b), .pix_data(data_b), .busy(busy_b), .frame_done(done_b),
        .dout(dout_b), .dout_n(doutn_b)
`ifdef LED_BRIGHTNESS_EN
        , .brightness(bright_b)
`endif
    );

    localparam int LEN_A = 2 + 4 * 24 * 15 + 3600;   // 5042
    localparam int LEN_B = 2 + 1 * 24 * 15 + 3600;   // 3962

    bit exp_bit_q  [2][$];
    int exp_addr_q [2][$];
    int exp_len_q  [2][$];
    int exp_rst_q  [2][$];

    int errors = 0, checks = 0, cyc = 0, timeouts = 0;
    bit end_req = 1'b0, end_ack = 1'b0;

    int fs [2] = '{0, 0};
    int last_rise [2] = '{-1, -1};
    int hi_len [2] = '{0, 0};
    int prev_addr [2] = '{0, 0};
    bit prev_busy [2] = '{1'b0, 1'b0};
    bit prev_dout [2] = '{1'b0, 1'b0};
    bit prev_done [2] = '{1'b0, 1'b0};

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        bit bsy, dn, d, dnn, bitv, ok;
        int ad, e;
        cyc++;
        for (int ch = 0; ch < 2; ch++) begin
            bsy = (ch == 0) ? busy_a  : busy_b;
            dn  = (ch == 0) ? done_a  : done_b;
            d   = (ch == 0) ? dout_a  : dout_b;
            dnn = (ch == 0) ? doutn_a : doutn_b;
            ad  = (ch == 0) ? int'(addr_a) : int'(addr_b);
            if (!rst_n) begin
                if (exp_rst_q[ch].size() != 0) begin
                    void'(exp_rst_q[ch].pop_front());
                    check(d == 1'b0,   "rst_dout",       int'(d),   0);
                    check(dnn == 1'b1, "rst_dout_n",     int'(dnn), 1);
                    check(bsy == 1'b0, "rst_busy",       int'(bsy), 0);
                    check(dn == 1'b0,  "rst_frame_done", int'(dn),  0);
                    check(ad == 0,     "rst_pix_addr",   ad,        0);
                end
                prev_busy[ch] = 1'b0;
                prev_dout[ch] = 1'b0;
                prev_done[ch] = 1'b0;
                hi_len[ch]    = 0;
                last_rise[ch] = -1;
            end else begin
                if (bsy && !prev_busy[ch]) begin
                    fs[ch]        = cyc;
                    last_rise[ch] = -1;
                end
                if (bsy && (!prev_busy[ch] || ad != prev_addr[ch])) begin
                    ok = (exp_addr_q[ch].size() != 0);
                    check(ok, "addr_unexpected", ad, -1);
                    if (ok) begin
                        e = exp_addr_q[ch].pop_front();
                        check(ad == e, "pix_addr", ad, e);
                    end
                end
                if (d && !prev_dout[ch]) begin
                    check(dnn == 1'b0, "dout_n_rise", int'(dnn), 0);
                    check(bsy == 1'b1, "dout_while_busy", int'(bsy), 1);
                    if (last_rise[ch] < 0)
                        check(cyc - fs[ch] == 2, "first_bit_offset", cyc - fs[ch], 2);
                    else
                        check(cyc - last_rise[ch] == 15, "cell_len", cyc - last_rise[ch], 15);
                    last_rise[ch] = cyc;
                    hi_len[ch]    = 1;
                end else if (d) begin
                    hi_len[ch]++;
                end
                if (!d && prev_dout[ch]) begin
                    check(dnn == 1'b1, "dout_n_fall", int'(dnn), 1);
                    check(hi_len[ch] == 4 || hi_len[ch] == 10, "pulse_width", hi_len[ch], 10);
                    bitv = (hi_len[ch] == 10);
                    ok = (exp_bit_q[ch].size() != 0);
                    check(ok, "bit_unexpected", int'(bitv), -1);
                    if (ok) begin
                        e = int'(exp_bit_q[ch].pop_front());
                        check(int'(bitv) == e, "bit", int'(bitv), e);
                    end
                end
                if (dn) begin
                    check(bsy == 1'b1, "done_while_busy", int'(bsy), 1);
                    ok = (exp_len_q[ch].size() != 0);
                    check(ok, "frame_unexpected", cyc - fs[ch] + 1, -1);
                    if (ok) begin
                        e = exp_len_q[ch].pop_front();
                        check(cyc - fs[ch] + 1 == e, "frame_len", cyc - fs[ch] + 1, e);
                    end
                    fs[ch]        = cyc + 1;
                    last_rise[ch] = -1;
                end
                if (!bsy && prev_busy[ch]) begin
                    check(prev_done[ch] == 1'b1, "busy_fall_after_done", int'(prev_done[ch]), 1);
                    check(ad == 0, "idle_pix_addr", ad, 0);
                end
                prev_busy[ch] = bsy;
                prev_dout[ch] = d;
                prev_done[ch] = dn;
                prev_addr[ch] = ad;
            end
        end
        if (end_req && !end_ack) begin
            for (int ch = 0; ch < 2; ch++) begin
                check(exp_bit_q[ch].size() == 0,  "bits_missing",   exp_bit_q[ch].size(),  0);
                check(exp_addr_q[ch].size() == 0, "addrs_missing",  exp_addr_q[ch].size(), 0);
                check(exp_len_q[ch].size() == 0,  "frames_missing", exp_len_q[ch].size(),  0);
                check(exp_rst_q[ch].size() == 0,  "rst_missing",    exp_rst_q[ch].size(),  0);
            end
            check(timeouts == 0, "wait_timeout", timeouts, 0);
            end_ack = 1'b1;
        end
    end

    task automatic push_pixel(input int ch, input logic [23:0] w, input int addr);
        exp_addr_q[ch].push_back(addr);
        for (int i = 23; i >= 0; i--) exp_bit_q[ch].push_back(w[i]);
    endtask

    task automatic push_frame_a();
        for (int p = 0; p < 4; p++) push_pixel(0, mem_a[p], p);
        exp_len_q[0].push_back(LEN_A);
    endtask

    task automatic pulse(input int ch);
        @(negedge clk);
        if (ch == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_idle(input int ch);
        int n = 0;
        while (((ch == 0) ? busy_a : busy_b) && n < 8000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8000) timeouts++;
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_done(input int ch);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((ch == 0) ? done_a : done_b) && n < 6000);
        if (!((ch == 0) ? done_a : done_b)) timeouts++;
    endtask

    initial begin
        int n;
        exp_rst_q[0].push_back(1);
        exp_rst_q[1].push_back(1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1-pixel frame, 24'h800001: long, 22 short, long, then the latch gap.
        push_pixel(1, 24'h800001, 0);
        exp_len_q[1].push_back(LEN_B);
        pulse(1);
        wait_idle(1);

        // 4-pixel frame through the prefetch path.
        push_frame_a();
        pulse(0);
        wait_idle(0);

        // Starts mid-SEND and on the frame_done cycle are dropped.
        push_frame_a();
        pulse(0);
        repeat (300) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_idle(0);
        repeat (50) @(negedge clk);

        // Three back-to-back frames in continuous mode.
        cont_a = 1'b1;
        for (int f = 0; f < 3; f++) push_frame_a();
        pulse(0);
        wait_done(0);
        wait_done(0);
        @(negedge clk);
        cont_a = 1'b0;
        wait_idle(0);

        // Reset at the start of bit 37: 37 bits and addresses 0,1 go out first.
        push_pixel(0, mem_a[0], 0);
        exp_addr_q[0].push_back(1);
        for (int i = 0; i < 13; i++) exp_bit_q[0].push_back(mem_a[1][23-i]);
        exp_rst_q[0].push_back(1);
        exp_rst_q[1].push_back(1);
        pulse(0);
        repeat (557) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        push_frame_a();
        pulse(0);
        wait_idle(0);

`ifdef LED_BRIGHTNESS_EN
        // brightness 127 on 24'hFF8001 transmits 24'h7F4000.
        mem_b    = 24'hFF8001;
        bright_b = 8'd127;
        push_pixel(1, 24'h7F4000, 0);
        exp_len_q[1].push_back(LEN_B);
        pulse(1);
        wait_idle(1);
        bright_b = 8'd255;
`endif

        end_req = 1'b1;
        n = 0;
        while (!end_ack && n < 10) begin
            @(negedge clk);
            n++;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
